// File: rtl/mux_encode_if.sv
// Select-encoder bus: sweep request and configuration from the line timing controller,
// select code and sweep status towards the mux pins.
interface mux_encode_if #(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned GAP_W   = 8
);
  logic               start;
  logic [1:0]         ch_cnt;
  logic [DWELL_W-1:0] dwell;
  logic [GAP_W-1:0]   gap;
  logic               da;
  logic               db;
  logic               mux_en;
  logic [1:0]         ch;
  logic               busy;
  logic               done;

  modport master (
    output start, ch_cnt, dwell, gap,
    input  da, db, mux_en, ch, busy, done
  );

  modport slave (
    input  start, ch_cnt, dwell, gap,
    output da, db, mux_en, ch, busy, done
  );
endinterface

// File: rtl/mux_encode.sv
// Sequenced mux-select encoder: sweeps channels 0..ch_cnt, holding each for a dwell time
// with an optional break-before-make gap, driving the {da,db} code the decoder inverts.
module mux_encode #(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned GAP_W   = 8
) (
  input logic         clk,
  input logic         rst,
  mux_encode_if.slave bus
);
  localparam int unsigned CntW = (DWELL_W > GAP_W) ? DWELL_W : GAP_W;

  typedef enum logic [1:0] {StIdle, StGap, StDrive, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         ch_q, ch_d;
  logic [1:0]         last_q, last_d;
  logic [1:0]         code_q, code_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [DWELL_W-1:0] dwell_eff;

  // Decoder inverse: 0->11, 1->00, 2->10, 3->01.
  function automatic logic [1:0] encode(input logic [1:0] c);
    logic [1:0] code;
    unique case (c)
      2'd0:    code = 2'b11;
      2'd1:    code = 2'b00;
      2'd2:    code = 2'b10;
      default: code = 2'b01;
    endcase
    return code;
  endfunction

  assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    gap_d   = gap_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          last_d  = bus.ch_cnt;
          gap_d   = bus.gap;
          dwell_d = dwell_eff;
          ch_d    = 2'd0;
          if (bus.gap != '0) begin
            state_d = StGap;
            cnt_d   = CntW'(bus.gap) - CntW'(1);
          end else begin
            state_d = StDrive;
            cnt_d   = CntW'(dwell_eff) - CntW'(1);
          end
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StDrive;
          cnt_d   = CntW'(dwell_q) - CntW'(1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDrive: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (ch_q == last_q) begin
          state_d = StDone;
        end else begin
          // Code changes on the first gap cycle, or mid-drive when there is no gap.
          ch_d = ch_q + 2'd1;
          if (gap_q != '0) begin
            state_d = StGap;
            cnt_d   = CntW'(gap_q) - CntW'(1);
          end else begin
            cnt_d = CntW'(dwell_q) - CntW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    code_d = encode(ch_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ch_q    <= 2'd0;
      last_q  <= 2'd0;
      code_q  <= 2'b11;
      cnt_q   <= '0;
      dwell_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.da     = code_q[1];
  assign bus.db     = code_q[0];
  assign bus.ch     = ch_q;
  assign bus.mux_en = (state_q == StDrive);
  assign bus.busy   = (state_q == StGap) || (state_q == StDrive);
  assign bus.done   = (state_q == StDone);
endmodule

// File: doc/mux_encode.md
# mux_encode

Sequenced mux-select encoder for the panel test pattern path. It is the transmit-side counterpart of the mux decoder: it sweeps channel indices 0..N-1 and drives the 2-bit {da, db} select code that the decoder maps back to channel index `a`. Each channel is held for a programmable dwell time, with an optional break-before-make gap during which `mux_en` is low. Sits between the line timing controller, which issues `start`, and the mux select pins.

## Interface
- `DWELL_W`, default 16: width of the dwell counter and the `dwell` input.
- `GAP_W`, default 8: width of the gap counter and the `gap` input.

- `clk` input 1: system clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `start` input 1: one-cycle sweep request; honoured only in IDLE.
- `ch_cnt` input 2: number of channels to sweep minus 1 (0 means 1 channel, 3 means 4 channels).
- `dwell` input DWELL_W: drive cycles per channel; 0 is treated as 1.
- `gap` input GAP_W: enable-low cycles before each channel; 0 means no gap.
- `da` output 1: select code bit, registered.
- `db` output 1: select code bit, registered.
- `mux_en` output 1: high while a channel is being driven.
- `ch` output 2: current channel index.
- `busy` output 1: high from the cycle after `start` until the sweep ends.
- `done` output 1: one-cycle pulse when the sweep completes.

## Operation
- Encoding is fixed and is the exact inverse of the decoder: ch 0 -> {da,db}=11, ch 1 -> 00, ch 2 -> 10, ch 3 -> 01.
- `da` and `db` are always the registered encoding of `ch`. They never glitch while `mux_en` is high.
- FSM states are IDLE, GAP, DRIVE, DONE.
  - IDLE: when `start` is high, latch `ch_cnt`, `gap`, and `dwell` (converting dwell 0 to 1), set ch=0, and go to GAP if gap>0, otherwise to DRIVE.
  - GAP: `mux_en`=0 and the code already shows the new ch, giving setup time. After `gap` cycles, go to DRIVE.
  - DRIVE: `mux_en`=1 for `dwell` cycles. Then, if ch == latched ch_cnt, go to DONE. Otherwise increment ch and go to GAP, or straight to DRIVE if gap=0.
  - DONE: `done`=1, `busy`=0, `mux_en`=0 for exactly one cycle, then return to IDLE.
- Inputs are sampled only at start. Changes to them mid-sweep have no effect.
- `start` in any state other than IDLE is ignored. It is not queued.
- ch never exceeds the latched ch_cnt. There is no wrap-around within a sweep.
- In IDLE, `ch`, `da`, and `db` hold the last channel driven.

## Timing
- Reset values: state IDLE, ch=0, da=1, db=1, mux_en=0, busy=0, done=0.
- `rst` mid-sweep aborts the sweep on the next edge and forces the reset values. No `done` pulse is produced.
- `start` sampled high at edge T gives busy=1 and ch=0 from T+1.
  - If gap=0, mux_en=1 from T+1.
  - If gap>0, mux_en=1 from T+1+gap.
- Per channel: exactly `gap` cycles with mux_en=0, followed by exactly max(dwell,1) cycles with mux_en=1.
- The ch/code change coincides with the first GAP cycle. When gap=0 it coincides with the first DRIVE cycle of the next channel, and mux_en stays high across the change.
- Busy duration: (ch_cnt+1) × (gap + max(dwell,1)) cycles. `done` is asserted in the following cycle.
- `start` asserted in the DONE cycle is ignored. `start` in the first IDLE cycle after DONE is accepted.

## Test plan
- ch_cnt=3, dwell=4, gap=2, start pulse: {da,db} sequence is 11,00,10,01; each code shows 2 cycles with mux_en=0 then 4 cycles with mux_en=1. busy lasts 24 cycles, then done is high for 1 cycle, and ch stays 3 afterwards.
- ch_cnt=3, dwell=0, gap=0: ch goes 0,1,2,3 on consecutive cycles with mux_en continuously high. busy lasts 4 cycles, then done.
- ch_cnt=0, dwell=5, gap=1: one cycle with mux_en=0 and code 11, then 5 cycles with mux_en=1, then done. busy lasts 6 cycles.
- `start` re-pulsed during DRIVE of ch 1, and `dwell` changed mid-sweep: the sweep is unaffected, busy length is unchanged, and there is only one done pulse.
- Assert rst during GAP of ch 2: the next cycle shows ch=0, da=db=1, mux_en=0, busy=0, with no done pulse. A new start then performs a full sweep.
- Loopback: feed `da`/`db` into the mux decoder. The decoder output `a` equals `ch` one cycle later for every code of a 4-channel sweep.
